// File: rtl/proc_pkg.sv
// Shared types and instruction field layout for the accumulator processor front end.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fseq_state_t;

  localparam int unsigned OPCODE_MSB = 8;
  localparam int unsigned OPCODE_LSB = 5;
  localparam int unsigned ID_BIT     = 4;
  localparam int unsigned OPERAND_W  = 4;

  typedef struct packed {
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic                           identifier;
    logic [OPERAND_W-1:0]           operand;
  } instr_t;

endpackage

// File: rtl/branch_target.sv
// Branch target computation: lookup-table target or PC-relative with a signed operand.
module branch_target
  import proc_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0]      exec_pc_i,
  input  logic [OPERAND_W-1:0] operand_i,
  input  logic                 lookup_i,
  input  logic [PC_W-1:0]      lut_target_i,
  output logic [PC_W-1:0]      target_o
);

  logic [PC_W-1:0] offset;

  // Sign-extend the operand; the add wraps modulo 2^PC_W.
  assign offset   = {{(PC_W-OPERAND_W){operand_i[OPERAND_W-1]}}, operand_i};
  assign target_o = lookup_i ? lut_target_i : (exec_pc_i + offset);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, one-deep instruction register and run/halt sequencing for the processor.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned INSTR_W    = 9,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned START_ADDR = 0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [3:0]         opcode,
  output logic               identifier,
  output logic [3:0]         operand,
  output logic               ir_valid,
  input  logic               halt,
  input  logic               branch,
  input  logic               cond,
  input  logic               Lookup,
  input  logic [PC_W-1:0]    lut_target,
  output logic [PC_W-1:0]    exec_pc,
  output logic               Ack,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [PC_W-1:0] StartPc = PC_W'(START_ADDR);

  fseq_state_t        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic [PC_W-1:0]    exec_pc_q, exec_pc_d;
  logic               ack_q, ack_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    target;

  branch_target #(
    .PC_W(PC_W)
  ) u_branch_target (
    .exec_pc_i   (exec_pc_q),
    .operand_i   (ir_q[OPERAND_W-1:0]),
    .lookup_i    (Lookup),
    .lut_target_i(lut_target),
    .target_o    (target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    exec_pc_d  = exec_pc_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d    = RUN;
          pc_d       = StartPc;
          ir_valid_d = 1'b0;
          cnt_d      = '0;
          ack_d      = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (ir_valid_q && halt) begin
          // Halt wins over branch; PC, IR and exec_pc freeze for DONE.
          state_d    = DONE;
          ir_valid_d = 1'b0;
          ack_d      = 1'b1;
        end else begin
          ir_d       = instr_in;
          exec_pc_d  = pc_q;
          pc_d       = pc_q + PC_W'(1);
          ir_valid_d = 1'b1;
          if (ir_valid_q && branch && cond) begin
            // The word fetched this cycle is on the wrong path: squash it.
            pc_d       = target;
            ir_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      pc_q       <= StartPc;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      exec_pc_q  <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      exec_pc_q  <= exec_pc_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
    end
  end

  assign instr_addr  = pc_q;
  assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign identifier  = ir_q[ID_BIT];
  assign operand     = ir_q[OPERAND_W-1:0];
  assign ir_valid    = ir_valid_q;
  assign exec_pc     = exec_pc_q;
  assign Ack         = ack_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance with a 4-bit counter checks saturation.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        halt, branch, cond, Lookup;
  logic [9:0]  lut_target;

  logic [9:0]  instr_addr, exec_pc;
  logic [8:0]  instr_in;
  logic [3:0]  opcode, operand;
  logic        identifier, ir_valid, Ack;
  logic [15:0] cycle_count;

  logic [9:0]  s_addr, s_exec_pc;
  logic [8:0]  s_instr_in;
  logic [3:0]  s_opcode, s_operand;
  logic        s_identifier, s_ir_valid, s_ack;
  logic [3:0]  s_count;

  logic [8:0]  rom [0:1023];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_run = 1'b0;

  assign instr_in   = rom[instr_addr];
  assign s_instr_in = rom[s_addr];

  fetch_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .instr_addr(instr_addr), .instr_in(instr_in),
    .opcode(opcode), .identifier(identifier), .operand(operand), .ir_valid(ir_valid),
    .halt(halt), .branch(branch), .cond(cond), .Lookup(Lookup), .lut_target(lut_target),
    .exec_pc(exec_pc), .Ack(Ack), .cycle_count(cycle_count)
  );

  fetch_sequencer #(.CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .instr_addr(s_addr), .instr_in(s_instr_in),
    .opcode(s_opcode), .identifier(s_identifier), .operand(s_operand), .ir_valid(s_ir_valid),
    .halt(halt), .branch(branch), .cond(cond), .Lookup(Lookup), .lut_target(lut_target),
    .exec_pc(s_exec_pc), .Ack(s_ack), .cycle_count(s_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    if (exp_run && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  task automatic clear_strobes();
    halt = 0; branch = 0; cond = 0; Lookup = 0; lut_target = '0;
  endtask

  task automatic test_reset();
    Reset_n = 0; Start = 0; clear_strobes();
    #3;
    n_cmp++; if (instr_addr !== 10'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", instr_addr); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
    n_cmp++; if (Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", Ack); end
    n_cmp++; if (exec_pc !== 10'd0) begin n_err++; $display("FAIL reset_exec_pc: got %0d want 0", exec_pc); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    n_cmp++; if (opcode !== 4'd0) begin n_err++; $display("FAIL reset_opcode: got %0d want 0", opcode); end
    tick(); tick();
    Reset_n = 1;
    tick(); tick();
    n_cmp++; if (instr_addr !== 10'd0 || ir_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_hold: got pc=%0d v=%b want pc=0 v=0", instr_addr, ir_valid);
    end
  endtask

  task automatic test_seq_fetch();
    Start = 1;
    tick();
    exp_cnt = 0; exp_run = 1;
    n_cmp++; if (instr_addr !== 10'd0 || ir_valid !== 1'b0 || cycle_count !== 16'd0) begin
      n_err++; $display("FAIL run_entry: got pc=%0d v=%b cnt=%0d want 0/0/0", instr_addr, ir_valid, cycle_count);
    end
    // Start stays high for one RUN cycle and must be ignored.
    for (int n = 0; n < 4; n++) begin
      tick();
      Start = 0;
      n_cmp++; if (opcode !== rom[n][8:5] || operand !== rom[n][3:0]) begin
        n_err++; $display("FAIL seq_ir[%0d]: got op=%h opd=%h want op=%h opd=%h", n, opcode, operand, rom[n][8:5], rom[n][3:0]);
      end
      n_cmp++; if (exec_pc !== 10'(n) || ir_valid !== 1'b1 || instr_addr !== 10'(n + 1)) begin
        n_err++; $display("FAIL seq_pc[%0d]: got exec=%0d v=%b pc=%0d want exec=%0d v=1 pc=%0d", n, exec_pc, ir_valid, instr_addr, n, n + 1);
      end
      n_cmp++; if (cycle_count !== exp_cnt) begin
        n_err++; $display("FAIL seq_count[%0d]: got %0d want %0d", n, cycle_count, exp_cnt);
      end
    end
  endtask

  task automatic test_rel_branch();
    tick(); tick();
    n_cmp++; if (exec_pc !== 10'd5 || operand !== 4'b1110) begin
      n_err++; $display("FAIL rel_setup: got exec=%0d opd=%b want 5/1110", exec_pc, operand);
    end
    branch = 1; cond = 1;
    tick();
    clear_strobes();
    n_cmp++; if (ir_valid !== 1'b0 || instr_addr !== 10'd3) begin
      n_err++; $display("FAIL rel_bubble: got v=%b pc=%0d want v=0 pc=3", ir_valid, instr_addr);
    end
    halt = 1;
    tick();
    halt = 0;
    n_cmp++; if (exec_pc !== 10'd3 || ir_valid !== 1'b1 || Ack !== 1'b0 || instr_addr !== 10'd4) begin
      n_err++; $display("FAIL rel_target: got exec=%0d v=%b ack=%b pc=%0d want 3/1/0/4", exec_pc, ir_valid, Ack, instr_addr);
    end
    tick(); tick();
    branch = 1; cond = 0;
    tick();
    clear_strobes();
    n_cmp++; if (exec_pc !== 10'd6 || ir_valid !== 1'b1) begin
      n_err++; $display("FAIL untaken: got exec=%0d v=%b want 6/1", exec_pc, ir_valid);
    end
  endtask

  task automatic test_lookup_wrap();
    tick(); tick();
    Lookup = 1; branch = 1; cond = 1; lut_target = 10'd200;
    tick();
    clear_strobes();
    n_cmp++; if (ir_valid !== 1'b0 || instr_addr !== 10'd200) begin
      n_err++; $display("FAIL lut_bubble: got v=%b pc=%0d want v=0 pc=200", ir_valid, instr_addr);
    end
    tick();
    n_cmp++; if (exec_pc !== 10'd200 || ir_valid !== 1'b1 || opcode !== rom[200][8:5]) begin
      n_err++; $display("FAIL lut_target: got exec=%0d v=%b op=%h want 200/1/%h", exec_pc, ir_valid, opcode, rom[200][8:5]);
    end
    Lookup = 1; branch = 1; cond = 1; lut_target = 10'd1022;
    tick();
    clear_strobes();
    tick(); tick();
    n_cmp++; if (exec_pc !== 10'd1023 || instr_addr !== 10'd0) begin
      n_err++; $display("FAIL wrap: got exec=%0d pc=%0d want 1023/0", exec_pc, instr_addr);
    end
    tick();
    n_cmp++; if (exec_pc !== 10'd0 || ir_valid !== 1'b1 || opcode !== rom[0][8:5]) begin
      n_err++; $display("FAIL wrap_fetch: got exec=%0d v=%b op=%h want 0/1/%h", exec_pc, ir_valid, opcode, rom[0][8:5]);
    end
  endtask

  task automatic test_halt();
    Lookup = 1; branch = 1; cond = 1; lut_target = 10'd12;
    tick();
    clear_strobes();
    tick();
    halt = 1; branch = 1; cond = 1; Lookup = 1; lut_target = 10'd500;
    tick();
    exp_run = 0;
    n_cmp++; if (Ack !== 1'b1 || ir_valid !== 1'b0 || instr_addr !== 10'd13 || exec_pc !== 10'd12) begin
      n_err++; $display("FAIL halt: got ack=%b v=%b pc=%0d exec=%0d want 1/0/13/12", Ack, ir_valid, instr_addr, exec_pc);
    end
    n_cmp++; if (opcode !== rom[12][8:5] || cycle_count !== exp_cnt) begin
      n_err++; $display("FAIL halt_hold: got op=%h cnt=%0d want %h/%0d", opcode, cycle_count, rom[12][8:5], exp_cnt);
    end
    tick(); tick();
    n_cmp++; if (Ack !== 1'b1 || instr_addr !== 10'd13 || cycle_count !== exp_cnt) begin
      n_err++; $display("FAIL done_stable: got ack=%b pc=%0d cnt=%0d want 1/13/%0d", Ack, instr_addr, cycle_count, exp_cnt);
    end
    clear_strobes();
    Start = 1;
    tick();
    Start = 0; exp_cnt = 0; exp_run = 1;
    n_cmp++; if (Ack !== 1'b0 || instr_addr !== 10'd0 || ir_valid !== 1'b0 || cycle_count !== 16'd0) begin
      n_err++; $display("FAIL restart: got ack=%b pc=%0d v=%b cnt=%0d want 0/0/0/0", Ack, instr_addr, ir_valid, cycle_count);
    end
    tick();
    n_cmp++; if (exec_pc !== 10'd0 || ir_valid !== 1'b1 || cycle_count !== 16'd1) begin
      n_err++; $display("FAIL restart_fetch: got exec=%0d v=%b cnt=%0d want 0/1/1", exec_pc, ir_valid, cycle_count);
    end
  endtask

  task automatic test_reset_midrun();
    Lookup = 1; branch = 1; cond = 1; lut_target = 10'd37;
    tick();
    clear_strobes();
    n_cmp++; if (instr_addr !== 10'd37) begin
      n_err++; $display("FAIL midrun_setup: got pc=%0d want 37", instr_addr);
    end
    #2 Reset_n = 0;
    #1;
    exp_run = 0; exp_cnt = 0;
    n_cmp++; if (instr_addr !== 10'd0 || ir_valid !== 1'b0 || Ack !== 1'b0 || exec_pc !== 10'd0 || cycle_count !== 16'd0) begin
      n_err++; $display("FAIL async_reset: got pc=%0d v=%b ack=%b exec=%0d cnt=%0d want all 0", instr_addr, ir_valid, Ack, exec_pc, cycle_count);
    end
    tick();
    Reset_n = 1;
    tick(); tick();
    n_cmp++; if (instr_addr !== 10'd0 || ir_valid !== 1'b0 || Ack !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got pc=%0d v=%b ack=%b want 0/0/0", instr_addr, ir_valid, Ack);
    end
  endtask

  task automatic test_saturation();
    Start = 1;
    tick();
    Start = 0; exp_cnt = 0; exp_run = 1;
    n_cmp++; if (s_count !== 4'd0) begin n_err++; $display("FAIL sat_start: got %0d want 0", s_count); end
    repeat (20) tick();
    n_cmp++; if (cycle_count !== 16'd20) begin n_err++; $display("FAIL count20: got %0d want 20", cycle_count); end
    n_cmp++; if (s_count !== 4'd15) begin n_err++; $display("FAIL saturate: got %0d want 15", s_count); end
    n_cmp++; if (s_ir_valid !== 1'b1 || s_exec_pc !== 10'd19) begin
      n_err++; $display("FAIL sat_run: got v=%b exec=%0d want 1/19", s_ir_valid, s_exec_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 37 + 5) % 512);
    rom[5] = 9'b1010_0_1110;
    test_reset();
    test_seq_fetch();
    test_rel_branch();
    test_lookup_wrap();
    test_halt();
    test_reset_midrun();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front end of the accumulator processor. It owns the program counter, fetches 9-bit instructions from the combinational instruction ROM into a one-deep instruction register, and presents opcode/identifier/operand to the control decoder. It consumes the decoder's start/halt/branch/Lookup strobes to sequence, redirect, and stop execution. It also counts executed cycles.

Parameters:
PC_W, 10, program counter / ROM address width
INSTR_W, 9, instruction width: opcode[8:5], identifier[4], operand[3:0]
CNT_W, 16, cycle counter width
START_ADDR, 0, PC value loaded on Start

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  external run request; level sampled each cycle
instr_addr  out  PC_W  ROM address (equal to fetch PC)
instr_in  in  INSTR_W  ROM data for instr_addr, same cycle
opcode  out  4  IR[8:5] to decoder
identifier  out  1  IR[4] to decoder
operand  out  4  IR[3:0] to decoder/ALU
ir_valid  out  1  IR holds a live instruction; decoder strobes qualified by it
halt  in  1  decoder: stop after this instruction
branch  in  1  decoder: instruction is a branch
cond  in  1  ALU/flag: branch condition true
Lookup  in  1  decoder: target comes from lookup table
lut_target  in  PC_W  lookup-table target addressed by operand
exec_pc  out  PC_W  PC of the instruction in IR
Ack  out  1  program finished (DONE state)
cycle_count  out  CNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset (Reset_n low, async): state=IDLE, fetch PC=START_ADDR, IR=0, ir_valid=0, exec_pc=0, Ack=0, cycle_count=0. All outputs go to these values immediately and are held while Reset_n is low. Reset mid-RUN abandons the program with no Ack.
- States:
  - IDLE -> RUN on Start=1.
  - RUN -> DONE on halt taken.
  - DONE -> RUN on Start=1.
  - Start is ignored while in RUN.
- Entering RUN (IDLE/DONE with Start): PC<=START_ADDR, ir_valid<=0, cycle_count<=0, Ack<=0. The first instruction appears in IR one cycle later.
- RUN, normal cycle:
  - IR<=instr_in; exec_pc<=PC; ir_valid<=1.
  - PC<=PC+1, modulo 2^PC_W (wraps from max to 0, no error).
  - Latency: ROM word at address A is on opcode/operand exactly 1 cycle after PC=A.
- Strobes are acted on only when ir_valid=1.
- Taken branch (ir_valid & branch & cond):
  - Target = Lookup ? lut_target : exec_pc + sign-extended operand. Arithmetic is modulo 2^PC_W.
  - PC<=target. The instruction fetched this cycle is squashed (ir_valid<=0), giving one bubble.
  - The target instruction is in IR 2 cycles after the branch was in IR.
- Untaken branch (branch & !cond): no effect; sequential fetch continues.
- Halt (ir_valid & halt):
  - state<=DONE, ir_valid<=0, Ack<=1. PC is frozen at its current value.
  - Halt has priority over branch when both are asserted.
- DONE: IR/PC held, ir_valid=0, Ack=1 until a Start restarts execution.
- cycle_count increments every RUN cycle, including bubbles, and saturates at all-ones. It is held in IDLE/DONE.
- Strobes with ir_valid=0 are ignored (bubble, IDLE, DONE).

Decomposition:
- Shared package proc_pkg holds:
  - state enum fseq_state_t {IDLE, RUN, DONE};
  - constants OPCODE_MSB/LSB, ID_BIT, OPERAND_W;
  - the instruction field typedef instr_t.
- One sub-module is natural: branch_target (combinational: exec_pc, operand, Lookup, lut_target -> target).
- All state and registers stay in fetch_sequencer.

Test Plan:
- Reset/IDLE: Reset_n low mid-RUN with PC=37 -> PC=0, ir_valid=0, Ack=0 at once, and held after release until Start.
- Sequential fetch: Start, ROM[0..3]=distinct words -> opcode/operand match ROM[n] in cycle n+1, exec_pc=n, ir_valid=1 from cycle 1.
- Relative branch: IR at exec_pc=5, operand=4'b1110, branch=cond=1 -> one bubble, then exec_pc=3. With cond=0 -> exec_pc=6 next, no bubble.
- Lookup branch: exec_pc=8, Lookup=branch=cond=1, lut_target=200 -> bubble, then exec_pc=200. PC=1023 sequential -> wraps to 0.
- Halt: halt and branch both asserted at exec_pc=12 -> DONE, Ack=1, ir_valid=0, PC frozen, cycle_count stable. Start again -> Ack=0, restart at 0, cycle_count cleared.
- Saturation: CNT_W=4 override, run 20 cycles -> cycle_count stops at 15.
